// File: rtl/mult8_iter_nibble_seq.sv
// Iterative 8x8 unsigned multiplier: one shared external 4x4 multiplier is driven over
// four nibble-pair steps, and the partial products are shift-accumulated into a 16-bit result.
module mult8_iter_nibble_seq #(
   parameter int unsigned MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic [3:0]  m_a,
   output logic [3:0]  m_b,
   input  logic [7:0]  m_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_p,
   output logic        busy
);

   localparam int unsigned CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MUL_LAT);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e         state_q, state_d;
   logic [7:0]     a_q, a_d, b_q, b_d;
   logic [15:0]    acc_q, acc_d;
   logic [1:0]     step_q, step_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    out_p_q, out_p_d;
   logic [3:0]     m_a_q, m_a_d, m_b_q, m_b_d;

   logic        accept;
   logic        last_cycle;
   logic [15:0] pp_shifted;
   logic [15:0] acc_sum;
   logic [7:0]  next_pair;

   // {A nibble, B nibble} for a step: ll, lh, hl, hh.
   function automatic logic [7:0] nib_pair(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
      unique case (s)
         2'd0:    nib_pair = {a[3:0], b[3:0]};
         2'd1:    nib_pair = {a[3:0], b[7:4]};
         2'd2:    nib_pair = {a[7:4], b[3:0]};
         default: nib_pair = {a[7:4], b[7:4]};
      endcase
   endfunction

   assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign accept     = in_valid && in_ready;
   assign last_cycle = (cnt_q == LAST_CNT);
   assign acc_sum    = acc_q + pp_shifted;
   assign next_pair  = nib_pair(a_q, b_q, step_q + 2'd1);

   always_comb begin
      pp_shifted = 16'h0000;
      unique case (step_q)
         2'd0:    pp_shifted = {8'h00, m_p};
         2'd1,
         2'd2:    pp_shifted = {4'h0, m_p, 4'h0};
         default: pp_shifted = {m_p, 8'h00};
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      out_p_d = out_p_q;
      m_a_d   = m_a_q;
      m_b_d   = m_b_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = StMul;
               a_d     = in_a;
               b_d     = in_b;
               acc_d   = 16'h0000;
               step_d  = 2'd0;
               cnt_d   = '0;
               m_a_d   = in_a[3:0];
               m_b_d   = in_b[3:0];
            end else if (state_q == StDone && out_ready) begin
               state_d = StIdle;
            end
         end
         StMul: begin
            if (last_cycle) begin
               acc_d = acc_sum;
               cnt_d = '0;
               if (step_q == 2'd3) begin
                  state_d = StDone;
                  out_p_d = acc_sum;
                  m_a_d   = 4'h0;
                  m_b_d   = 4'h0;
               end else begin
                  step_d = step_q + 2'd1;
                  m_a_d  = next_pair[7:4];
                  m_b_d  = next_pair[3:0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            m_a_d   = 4'h0;
            m_b_d   = 4'h0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         acc_q   <= 16'h0000;
         step_q  <= 2'd0;
         cnt_q   <= '0;
         out_p_q <= 16'h0000;
         m_a_q   <= 4'h0;
         m_b_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         out_p_q <= out_p_d;
         m_a_q   <= m_a_d;
         m_b_q   <= m_b_d;
      end
   end

   assign m_a       = m_a_q;
   assign m_b       = m_b_q;
   assign out_p     = out_p_q;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StMul);

endmodule
